// File: rtl/bean_pool_pkg.sv
// Shared types and constants for the obstacle ("bean") pool of the runner game.
package bean_pkg;

  localparam int POS_W    = 12;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Vertical bands in which each obstacle type is drawn (end exclusive).
  localparam int FLOOR_Y0_DEF = SCREEN_H - 80;
  localparam int FLOOR_Y1_DEF = SCREEN_H - 40;
  localparam int FLY_Y0_DEF   = 330;
  localparam int FLY_Y1_DEF   = 360;

  typedef enum logic {
    TYPE_FLOOR = 1'b0,
    TYPE_FLY   = 1'b1
  } bean_type_t;

  // Slot index width, kept at least one bit so a single-slot pool still elaborates.
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bean_pool_if.sv
// Game-side bundle of the bean pool: scroll/collision controls, pixel query and status.
interface bean_pool_if #(
  parameter int N_SLOTS = 4,
  parameter int POS_W   = bean_pkg::POS_W
);
  localparam int SLOT_W = bean_pkg::slot_w(N_SLOTS);
  localparam int CNT_W  = $clog2(N_SLOTS + 1);

  // No backpressure anywhere: shift_tick and hit_in are single-cycle pulses taken on
  // the edge they are high; x/y are sampled every edge and their answer
  // (bean/bean_type/bean_slot) is valid for exactly the following cycle.
  logic                            shift_tick;
  logic                            hit_in;
  logic [9:0]                      x;
  logic [9:0]                      y;
  logic                            bean;
  logic                            bean_type;
  logic [SLOT_W-1:0]               bean_slot;
  logic                            frozen;
  logic                            spawn_strobe;
  logic [CNT_W-1:0]                active_count;
  logic [N_SLOTS-1:0]              dbg_active;
  logic [N_SLOTS-1:0][POS_W-1:0]   dbg_pos;
  logic [POS_W-1:0]                dbg_rand_pos;

  modport master (
    output shift_tick, hit_in, x, y,
    input  bean, bean_type, bean_slot, frozen, spawn_strobe, active_count,
           dbg_active, dbg_pos, dbg_rand_pos
  );

  modport slave (
    input  shift_tick, hit_in, x, y,
    output bean, bean_type, bean_slot, frozen, spawn_strobe, active_count,
           dbg_active, dbg_pos, dbg_rand_pos
  );

endinterface

// File: rtl/bean_pool_lfsr.sv
// Spawn randomness: a free-running x-position counter and a 16-bit Galois LFSR for the type.
module bean_lfsr
  import bean_pkg::*;
#(
  parameter int          POS_W     = bean_pkg::POS_W,
  parameter int          RAND_MIN  = SCREEN_W,
  parameter int          RAND_MAX  = 790,
  parameter int          RAND_STEP = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk_rand,
  input  logic                    reset,
  output logic signed [POS_W-1:0] rand_pos,
  output bean_type_t              rand_type
);

  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t        RMIN_P  = pos_t'(RAND_MIN);
  localparam pos_t        RMAX_P  = pos_t'(RAND_MAX);
  localparam pos_t        RSTEP_P = pos_t'(RAND_STEP);
  // Taps 16,14,13,11 in right-shifting Galois form.
  localparam logic [15:0] TAPS    = 16'hB400;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_rand) begin
    if (reset) begin
      lfsr_q   <= LFSR_SEED;
      rand_pos <= RMIN_P;
    end else begin
      lfsr_q   <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
      rand_pos <= (rand_pos >= RMAX_P) ? RMIN_P : rand_pos + RSTEP_P;
    end
  end

  assign rand_type = bean_type_t'(lfsr_q[0]);

endmodule

// File: rtl/bean_pool.sv
// Obstacle pool: scrolls N_SLOTS beans left on shift_tick, recycles off-screen slots
// into new spawns, freezes on collision and answers registered per-pixel queries.
module bean_pool
  import bean_pkg::*;
#(
  parameter int          N_SLOTS      = 4,
  parameter int          POS_W        = bean_pkg::POS_W,
  parameter int          SHIFT        = 5,
  parameter int          BEAN_W       = 20,
  parameter int          START_X      = 750,
  parameter int          SPAWN_THRESH = 440,
  parameter int          RAND_MIN     = SCREEN_W,
  parameter int          RAND_MAX     = 790,
  parameter int          RAND_STEP    = 5,
  parameter int          FLOOR_Y0     = FLOOR_Y0_DEF,
  parameter int          FLOOR_Y1     = FLOOR_Y1_DEF,
  parameter int          FLY_Y0       = FLY_Y0_DEF,
  parameter int          FLY_Y1       = FLY_Y1_DEF,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk_rand,
  input  logic        reset,
  bean_pool_if.slave  bus
);

  localparam int SLOT_W = slot_w(N_SLOTS);
  localparam int CNT_W  = $clog2(N_SLOTS + 1);

  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t       SHIFT_P    = pos_t'(SHIFT);
  localparam pos_t       BEAN_W_P   = pos_t'(BEAN_W);
  localparam pos_t       GONE_P     = pos_t'(-BEAN_W);
  localparam pos_t       START_P    = pos_t'(START_X);
  localparam pos_t       THRESH_P   = pos_t'(SPAWN_THRESH);
  localparam logic [9:0] FLOOR_Y0_P = 10'(FLOOR_Y0);
  localparam logic [9:0] FLOOR_Y1_P = 10'(FLOOR_Y1);
  localparam logic [9:0] FLY_Y0_P   = 10'(FLY_Y0);
  localparam logic [9:0] FLY_Y1_P   = 10'(FLY_Y1);

  pos_t               pos_q [N_SLOTS];
  pos_t               pos_d [N_SLOTS];
  bean_type_t         typ_q [N_SLOTS];
  bean_type_t         typ_d [N_SLOTS];
  logic [N_SLOTS-1:0] act_q, act_d;
  pos_t               furthest_q, furthest_d;
  logic               frozen_q;
  logic               strobe_q, strobe_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bean_q, bean_d;
  bean_type_t         btype_q, btype_d;
  logic [SLOT_W-1:0]  bslot_q, bslot_d;
  logic               tick;
  logic               spawn_ok;
  logic               taken;
  pos_t               x_pos;
  pos_t               rand_pos;
  bean_type_t         rand_type;

  bean_lfsr #(
    .POS_W     (POS_W),
    .RAND_MIN  (RAND_MIN),
    .RAND_MAX  (RAND_MAX),
    .RAND_STEP (RAND_STEP),
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_rand  (clk_rand),
    .reset     (reset),
    .rand_pos  (rand_pos),
    .rand_type (rand_type)
  );

  function automatic logic in_band(input bean_type_t t, input logic [9:0] yy);
    if (t == TYPE_FLY) return (yy >= FLY_Y0_P) && (yy < FLY_Y1_P);
    return (yy >= FLOOR_Y0_P) && (yy < FLOOR_Y1_P);
  endfunction

  // A collision in the same cycle as a tick wins: the tick is dropped.
  assign tick = bus.shift_tick && !frozen_q && !bus.hit_in;

  always_comb begin
    pos_d      = pos_q;
    typ_d      = typ_q;
    act_d      = act_q;
    furthest_d = furthest_q;
    strobe_d   = 1'b0;
    spawn_ok   = 1'b0;
    taken      = 1'b0;
    cnt_d      = '0;
    if (tick) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (act_q[i]) begin
          pos_d[i] = pos_q[i] - SHIFT_P;
          if (pos_d[i] < GONE_P) act_d[i] = 1'b0;
        end
      end
      furthest_d = (furthest_q >= SHIFT_P) ? furthest_q - SHIFT_P : '0;
      spawn_ok   = (furthest_d <= THRESH_P);
    end
    // Slots freed by this very tick are already visible in act_d.
    for (int i = 0; i < N_SLOTS; i++) begin
      if (spawn_ok && !taken && !act_d[i]) begin
        taken    = 1'b1;
        pos_d[i] = rand_pos;
        typ_d[i] = rand_type;
        act_d[i] = 1'b1;
      end
    end
    if (taken) begin
      furthest_d = rand_pos;
      strobe_d   = 1'b1;
    end
    for (int i = 0; i < N_SLOTS; i++) cnt_d = cnt_d + CNT_W'(act_d[i]);
  end

  always_comb begin
    bean_d  = 1'b0;
    btype_d = TYPE_FLOOR;
    bslot_d = '0;
    x_pos   = pos_t'(bus.x);
    // Walk downwards so the lowest-index hit is the one that sticks.
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (act_q[i] && (pos_q[i] <= x_pos) && (x_pos < pos_q[i] + BEAN_W_P) &&
          in_band(typ_q[i], bus.y)) begin
        bean_d  = 1'b1;
        btype_d = typ_q[i];
        bslot_d = SLOT_W'(i);
      end
    end
  end

  always_ff @(posedge clk_rand) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        pos_q[i] <= (i == 0) ? START_P : '0;
        typ_q[i] <= TYPE_FLOOR;
      end
      act_q      <= N_SLOTS'(1);
      furthest_q <= START_P;
      frozen_q   <= 1'b0;
      strobe_q   <= 1'b0;
      cnt_q      <= CNT_W'(1);
      bean_q     <= 1'b0;
      btype_q    <= TYPE_FLOOR;
      bslot_q    <= '0;
    end else begin
      pos_q      <= pos_d;
      typ_q      <= typ_d;
      act_q      <= act_d;
      furthest_q <= furthest_d;
      frozen_q   <= frozen_q | bus.hit_in;
      strobe_q   <= strobe_d;
      cnt_q      <= cnt_d;
      bean_q     <= bean_d;
      btype_q    <= btype_d;
      bslot_q    <= bslot_d;
    end
  end

  assign bus.bean         = bean_q;
  assign bus.bean_type    = btype_q;
  assign bus.bean_slot    = bslot_q;
  assign bus.frozen       = frozen_q;
  assign bus.spawn_strobe = strobe_q;
  assign bus.active_count = cnt_q;
  assign bus.dbg_active   = act_q;
  assign bus.dbg_rand_pos = rand_pos;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_dbg
    assign bus.dbg_pos[g] = pos_q[g];
  end

endmodule

// File: tb/tb_bean_pool.sv
// Bench for bean_pool: directed scroll/spawn/query/freeze sequences plus a random run,
// all checked against a slot-list model of the pool rules.
module tb_bean_pool;
  import bean_pkg::*;

  localparam int N       = 4;
  localparam int SW      = 2;
  localparam int QW      = 2 + SW;
  localparam int START_X = 750;
  localparam int SHIFT   = 5;
  localparam int BEAN_W  = 20;
  localparam int THRESH  = 440;
  localparam int RMIN    = 640;
  localparam int RMAX    = 790;
  localparam int RSTEP   = 5;
  localparam int NCNT    = (RMAX - RMIN) / RSTEP + 1;

  logic clk_rand = 1'b0;
  logic reset    = 1'b1;
  always #5 clk_rand = ~clk_rand;

  bean_pool_if #(.N_SLOTS(N)) bif ();
  bean_pool_if #(.N_SLOTS(1)) bif1 ();

  bean_pool #(.N_SLOTS(N)) dut  (.clk_rand(clk_rand), .reset(reset), .bus(bif.slave));
  bean_pool #(.N_SLOTS(1)) dut1 (.clk_rand(clk_rand), .reset(reset), .bus(bif1.slave));

  // Model of the four-slot pool.
  int          m_pos [N];
  bit          m_act [N];
  bit          m_typ [N];
  int          m_far;
  bit          m_frozen;
  bit          m_strobe;
  int          m_cyc;
  logic [15:0] m_lfsr;

  logic [QW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] qx;
    logic [9:0] qy;
    bit         e_bean;
    bit         e_type;
    int         e_slot;
  } qvec_t;
  qvec_t qtab[7];

  function automatic int cnt_at(input int c);
    return RMIN + RSTEP * (c % NCNT);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int          taps[4];
    logic [15:0] mask;
    taps = '{16, 14, 13, 11};
    mask = '0;
    foreach (taps[k]) mask[taps[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic bit in_band(input bit t, input int yy);
    if (t) return (yy >= 330) && (yy < 360);
    return (yy >= 400) && (yy < 440);
  endfunction

  function automatic logic [QW-1:0] model_query(input int qx, input int qy);
    for (int i = 0; i < N; i++)
      if (m_act[i] && m_pos[i] <= qx && qx < m_pos[i] + BEAN_W && in_band(m_typ[i], qy))
        return {1'b1, m_typ[i], SW'(i)};
    return '0;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < N; i++) n += m_act[i];
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = (i == 0);
      m_pos[i] = (i == 0) ? START_X : 0;
      m_typ[i] = 1'b0;
    end
    m_far = START_X; m_frozen = 0; m_strobe = 0; m_cyc = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_all();
    logic [QW-1:0] e;
    e = exp_q.pop_front();
    chk("bean", int'(bif.bean), int'(e[QW-1]));
    chk("bean_type", int'(bif.bean_type), int'(e[QW-2]));
    chk("bean_slot", int'(bif.bean_slot), int'(e[SW-1:0]));
    chk("frozen", int'(bif.frozen), int'(m_frozen));
    chk("spawn_strobe", int'(bif.spawn_strobe), int'(m_strobe));
    chk("active_count", int'(bif.active_count), model_count());
    chk("rand_pos", int'($signed(bif.dbg_rand_pos)), cnt_at(m_cyc));
    for (int i = 0; i < N; i++) begin
      chk("slot_active", int'(bif.dbg_active[i]), int'(m_act[i]));
      if (m_act[i]) chk("slot_pos", int'($signed(bif.dbg_pos[i])), m_pos[i]);
    end
  endtask

  // One clock: drive inputs, advance the model by the pool rules, check after the edge.
  task automatic step(input bit rst, input bit st, input bit hit,
                      input logic [9:0] qx, input logic [9:0] qy);
    int c;
    bit t;
    bit done;
    reset = rst;
    bif.shift_tick  = st;  bif.hit_in  = hit; bif.x  = qx; bif.y  = qy;
    bif1.shift_tick = st;  bif1.hit_in = hit; bif1.x = qx; bif1.y = qy;
    if (rst) begin
      exp_q.push_back('0);
      model_reset();
    end else begin
      exp_q.push_back(model_query(int'(qx), int'(qy)));
      c = cnt_at(m_cyc);
      t = m_lfsr[0];
      m_strobe = 0;
      if (st && !m_frozen && !hit) begin
        for (int i = 0; i < N; i++)
          if (m_act[i]) begin
            m_pos[i] -= SHIFT;
            if (m_pos[i] < -BEAN_W) m_act[i] = 0;
          end
        m_far = (m_far - SHIFT < 0) ? 0 : m_far - SHIFT;
        done = 0;
        if (m_far <= THRESH)
          for (int i = 0; i < N; i++)
            if (!done && !m_act[i]) begin
              done = 1; m_act[i] = 1; m_pos[i] = c; m_typ[i] = t;
              m_far = c; m_strobe = 1;
            end
      end
      if (hit) m_frozen = 1;
      m_cyc++;
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(posedge clk_rand);
    #1;
    check_all();
  endtask

  // Queries: half aimed around a live slot (edges included), half anywhere.
  task automatic pick_q(output logic [9:0] qx, output logic [9:0] qy);
    int k;
    int xv;
    k = int'($urandom_range(0, N - 1));
    if (m_act[k] && $urandom_range(0, 1) == 1) begin
      xv = m_pos[k] + int'($urandom_range(0, 21)) - 1;
      qy = m_typ[k] ? 10'($urandom_range(329, 360)) : 10'($urandom_range(399, 440));
    end else begin
      xv = int'($urandom_range(0, 819));
      qy = 10'($urandom_range(0, 1023));
    end
    if (xv < 0) xv = 0;
    qx = 10'(xv);
  endtask

  initial begin
    logic [9:0] qx, qy;
    int c;
    int p0;

    qtab[0] = '{10'd205, 10'd400, 1'b1, 1'b0, 0};
    qtab[1] = '{10'd220, 10'd400, 1'b0, 1'b0, 0};
    qtab[2] = '{10'd205, 10'd399, 1'b0, 1'b0, 0};
    qtab[3] = '{10'd200, 10'd439, 1'b1, 1'b0, 0};
    qtab[4] = '{10'd219, 10'd420, 1'b1, 1'b0, 0};
    qtab[5] = '{10'd199, 10'd400, 1'b0, 1'b0, 0};
    qtab[6] = '{10'd205, 10'd440, 1'b0, 1'b0, 0};

    // Reset state.
    step(1, 0, 0, 10'd0, 10'd0);
    step(1, 0, 0, 10'd750, 10'd400);
    chk("reset_pos0", int'($signed(bif.dbg_pos[0])), 750);
    chk("reset_count", int'(bif.active_count), 1);
    chk("reset_bean", int'(bif.bean), 0);
    chk("reset_rand", int'($signed(bif.dbg_rand_pos)), 640);

    // Spawn counter sweep including the wrap back to RAND_MIN.
    for (int k = 1; k <= NCNT; k++) begin
      step(0, 0, 0, 10'd0, 10'd0);
      chk("cnt_sweep", int'($signed(bif.dbg_rand_pos)), RMIN + RSTEP * (k % NCNT));
    end

    // Scroll from reset; first spawn exactly at the threshold on tick 62.
    step(1, 0, 0, 10'd0, 10'd0);
    for (int t = 1; t <= 110; t++) begin
      pick_q(qx, qy);
      c = cnt_at(m_cyc);
      step(0, 1, 0, qx, qy);
      if (t == 61) begin
        chk("t61_strobe", int'(bif.spawn_strobe), 0);
        chk("t61_count", int'(bif.active_count), 1);
      end
      if (t == 62) begin
        chk("t62_pos0", int'($signed(bif.dbg_pos[0])), 440);
        chk("t62_strobe", int'(bif.spawn_strobe), 1);
        chk("t62_count", int'(bif.active_count), 2);
        chk("t62_pos1", int'($signed(bif.dbg_pos[1])), c);
        chk("n1_t62_strobe", int'(bif1.spawn_strobe), 0);
      end
    end
    chk("t110_pos0", int'($signed(bif.dbg_pos[0])), 200);

    // Query table against slot 0 at x=200, floor type.
    foreach (qtab[k]) begin
      step(0, 0, 0, qtab[k].qx, qtab[k].qy);
      chk("qtab_bean", int'(bif.bean), int'(qtab[k].e_bean));
      chk("qtab_slot", int'(bif.bean_slot), qtab[k].e_slot);
      chk("qtab_type", int'(bif.bean_type), int'(qtab[k].e_type));
    end

    // Single-slot pool: spawn deferred until slot 0 leaves at -25 on tick 155.
    for (int t = 111; t <= 155; t++) begin
      pick_q(qx, qy);
      c = cnt_at(m_cyc);
      step(0, 1, 0, qx, qy);
      if (t == 154) begin
        chk("n1_t154_pos", int'($signed(bif1.dbg_pos[0])), -20);
        chk("n1_t154_count", int'(bif1.active_count), 1);
        chk("n1_t154_strobe", int'(bif1.spawn_strobe), 0);
      end
      if (t == 155) begin
        chk("n1_t155_strobe", int'(bif1.spawn_strobe), 1);
        chk("n1_t155_pos", int'($signed(bif1.dbg_pos[0])), c);
        chk("n1_t155_count", int'(bif1.active_count), 1);
      end
    end

    // Collision together with a tick, then ticks while frozen.
    p0 = m_pos[0];
    step(0, 1, 1, 10'd0, 10'd0);
    chk("hit_frozen", int'(bif.frozen), 1);
    chk("hit_pos0", int'($signed(bif.dbg_pos[0])), p0);
    for (int t = 0; t < 20; t++) begin
      pick_q(qx, qy);
      step(0, 1, 0, qx, qy);
    end
    chk("frozen_pos0", int'($signed(bif.dbg_pos[0])), p0);

    // Reset while frozen.
    step(1, 1, 0, 10'd755, 10'd420);
    chk("rst_frozen", int'(bif.frozen), 0);
    chk("rst_pos0", int'($signed(bif.dbg_pos[0])), 750);
    chk("rst_count", int'(bif.active_count), 1);
    chk("rst_bean", int'(bif.bean), 0);

    // Random run with occasional collisions and resets.
    for (int n = 0; n < 3000; n++) begin
      pick_q(qx, qy);
      step($urandom_range(0, 999) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 1499) == 0, qx, qy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bean_pool.md
Name: bean_pool

Overview:
- Parametrised obstacle ("bean") pool manager for the runner game, running entirely in the clk_rand domain.
- Holds N_SLOTS obstacles, each with a position and a type, and scrolls them left on each shift_tick.
- Frees slots that leave the screen and spawns new obstacles at pseudo-random x positions and types.
- Freezes on collision and answers registered per-pixel "is obstacle" queries for the VGA draw path.

Parameters:
- N_SLOTS, 4, number of obstacle slots (2..8)
- POS_W, 12, signed obstacle x-position width
- SHIFT, 5, pixels moved per shift_tick
- BEAN_W, 20, obstacle width in pixels
- START_X, 750, slot 0 position after reset
- SPAWN_THRESH, 440, spawn allowed once furthest <= this value
- RAND_MIN, 640, lowest spawn x
- RAND_MAX, 790, highest spawn x
- RAND_STEP, 5, spawn-x counter increment
- FLOOR_Y0, 400, floor-type vertical band start (inclusive)
- FLOOR_Y1, 440, floor-type band end (exclusive)
- FLY_Y0, 330, flying-type band start
- FLY_Y1, 360, flying-type band end
- LFSR_SEED, 16'hACE1, type LFSR seed (must be nonzero)

Ports:
- clk_rand, in, 1, block clock
- reset, in, 1, synchronous, active-high
- shift_tick, in, 1, one-cycle pulse in clk_rand domain that advances the scroll
- hit_in, in, 1, collision detected; sets freeze
- x, in, 10, pixel column query
- y, in, 10, pixel row query
- bean, out, 1, queried pixel is inside an active obstacle (registered)
- bean_type, out, 1, type of the hit obstacle (0 = floor, 1 = flying)
- bean_slot, out, $clog2(N_SLOTS), index of the hit slot
- frozen, out, 1, freeze status
- spawn_strobe, out, 1, one-cycle pulse when a spawn occurs
- active_count, out, $clog2(N_SLOTS+1), number of active slots

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk_rand. Reset has priority over all other inputs.
- Reset state:
  - slot 0 active at START_X, type 0; all other slots free.
  - furthest = START_X; frozen = 0; spawn counter = RAND_MIN; LFSR = LFSR_SEED.
  - Outputs: bean = 0, bean_type = 0, bean_slot = 0, spawn_strobe = 0, active_count = 1.
- Spawn counter: advances by RAND_STEP every clk_rand cycle. After RAND_MAX it wraps to RAND_MIN. It keeps running while frozen.
- LFSR: 16-bit Galois LFSR, taps 16,14,13,11, steps every cycle. Bit 0 is the spawn type.
- Freeze: hit_in sets frozen on the next edge. frozen is sticky and is cleared only by reset. A shift_tick in the same cycle as hit_in is ignored.
- Tick, applied when shift_tick = 1 and frozen = 0 and hit_in = 0, all within one cycle:
  1. Every active slot: pos <= pos - SHIFT. If the new pos < -BEAN_W, the slot becomes free.
  2. furthest <= furthest - SHIFT, saturating at 0.
  3. If the new furthest <= SPAWN_THRESH and a free slot exists (counting slots freed in step 1), the lowest-index free slot gets pos = current spawn counter and type = LFSR[0]. furthest is then set to that pos and spawn_strobe pulses.
- Spawn limits: at most one spawn per tick. If no slot is free, the spawn is deferred to a later tick; furthest keeps saturating.
- active_count: registered, reflects the slot state after the edge.
- Pixel query (latency 1):
  - A slot hits when it is active, pos <= x < pos + BEAN_W using a signed compare with x zero-extended, and y is in its type's band.
  - On the next edge: bean = OR of all slot hits; bean_slot / bean_type come from the lowest-index hitting slot (both 0 when there is no hit).
  - Queries are answered while frozen.
- Arithmetic: all position math is signed POS_W. Positions never exceed RAND_MAX, so there is no overflow.

Decomposition:
- Shared package bean_pkg holds:
  - bean type encoding (TYPE_FLOOR = 0, TYPE_FLY = 1);
  - screen constants (640x480);
  - band defaults;
  - POS_W.
- One sub-module, bean_lfsr: LFSR plus the RAND_MIN..RAND_MAX spawn counter. Its outputs are rand_pos and rand_type.

Test Plan:
- Reset, then 62 shift_ticks: no spawn on ticks 1–61. On tick 62, slot 0 pos = 440 and spawn_strobe = 1; slot 1 becomes active at the current spawn counter value; active_count = 2.
- Reset, then 155 ticks with spawns disabled via a deferred-slot scenario (N_SLOTS=1): slot 0 pos = -25 on tick 155, the slot is freed, and the same tick respawns it at the counter value with spawn_strobe = 1.
- After 110 ticks (slot 0 pos = 200, type 0): query x=205, y=400 gives bean = 1, bean_slot = 0, bean_type = 0 one cycle later. Query x=220, y=400 gives bean = 0. Query x=205, y=399 gives bean = 0.
- hit_in and shift_tick in the same cycle: positions unchanged, frozen = 1 next cycle. 20 further ticks leave positions unchanged; queries are still answered.
- Mid-run reset with frozen = 1: next cycle frozen = 0, slot 0 = 750, active_count = 1, bean = 0.
- Spawn counter over 31 cycles after reset: 640, 645, …, 790, then back to 640 (wrap checked).
